flash_read_seq: RTL and testbench

- Digital read sequencer that sits directly upstream and downstream of the 8x8 NAND-style flash array macro.
- Accepts a 3-bit read command and drives the array's select lines, word lines and sense-amp strobes in a timed sequence.
- Captures the 8-bit sense-amp result and returns it over a valid/ready handshake.
- Instantiated beside the array inside the user project wrapper. All array controls are registered.

---
 rtl/flash_read_seq.sv | 201 ++++++++++++++++++++
 tb/tb_flash_read_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_seq.sv
// Read sequencer for the 8x8 NAND flash array: times select/word lines and sense strobes.
// Optional double-sense with mismatch flag under `FLASH_RD_DOUBLE_SENSE_EN.
module flash_read_seq #(
    parameter int unsigned T_SETUP     = 4,
    parameter int unsigned T_PRE       = 2,
    parameter int unsigned T_SENSE     = 3,
    parameter logic [3:0]  OUT_EN_MASK = 4'hF
) (
    input  logic       wb_clk_i,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_addr,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       rd_err,
    output logic       busy,
    output logic [1:0] ssl,
    output logic [1:0] gsl,
    output logic [3:0] wl0,
    output logic [3:0] wl1,
    output logic       sl,
    output logic       vbpw,
    output logic       sen1,
    output logic       sen2,
    output logic [3:0] out_en,
    input  logic [7:0] sa_out
);

    typedef enum logic [3:0] {
        StIdle, StSetup, StPre, StSense, StLatch, StRecov, StPre2, StSense2, StLatch2
    } state_e;

    localparam logic [3:0] SETUP_LD = 4'(T_SETUP - 1);
    localparam logic [3:0] PRE_LD   = 4'(T_PRE - 1);
    localparam logic [3:0] SENSE_LD = 4'(T_SENSE - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] addr_q, addr_d;
    logic       accept;

    logic       active, busy_d, sen1_d, sen2_d;
    logic [1:0] sel_d;
    logic [3:0] wl_sel, wl0_d, wl1_d, out_en_d;
    logic       rd_valid_d;
    logic [7:0] rd_data_d;

    assign cmd_ready = (state_q == StIdle) && !rd_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign sl        = 1'b0;
    assign vbpw      = 1'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                    cnt_d   = SETUP_LD;
                    addr_d  = cmd_addr;
                end
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    state_d = StPre;
                    cnt_d   = PRE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StPre, StPre2: begin
                if (cnt_q == 4'd0) begin
                    state_d = (state_q == StPre) ? StSense : StSense2;
                    cnt_d   = SENSE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StSense, StSense2: begin
                if (cnt_q == 4'd0) begin
                    state_d = (state_q == StSense) ? StLatch : StLatch2;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef FLASH_RD_DOUBLE_SENSE_EN
            StLatch: begin
                state_d = StPre2;
                cnt_d   = PRE_LD;
            end
`else
            StLatch:  state_d = StRecov;
`endif
            StLatch2: state_d = StRecov;
            StRecov:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Array controls are decoded from the next state so the registered lines
    // line up exactly with the state they belong to.
    always_comb begin
        active = (state_d != StIdle) && (state_d != StRecov);
        busy_d = (state_d != StIdle);
        sel_d  = 2'b00;
        wl_sel = ~(4'b0001 << addr_d[1:0]);
        wl0_d  = 4'h0;
        wl1_d  = 4'h0;
        if (active) begin
            sel_d = addr_d[2] ? 2'b10 : 2'b01;
            if (addr_d[2]) begin
                wl1_d = wl_sel;
            end else begin
                wl0_d = wl_sel;
            end
        end
        sen1_d   = (state_d == StPre) || (state_d == StPre2);
        sen2_d   = (state_d == StSense) || (state_d == StSense2);
        out_en_d = ((state_d == StLatch) || (state_d == StLatch2)) ? OUT_EN_MASK : 4'h0;
    end

    always_comb begin
        rd_valid_d = rd_valid;
        rd_data_d  = rd_data;
        if (rd_valid && rd_ready) begin
            rd_valid_d = 1'b0;
        end
        if (state_q == StRecov) begin
            rd_valid_d = 1'b1;
        end
`ifdef FLASH_RD_DOUBLE_SENSE_EN
        if (state_q == StLatch2) begin
            rd_data_d = sa_out;
        end
`else
        if (state_q == StLatch) begin
            rd_data_d = sa_out;
        end
`endif
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            addr_q   <= 3'd0;
            busy     <= 1'b0;
            ssl      <= 2'b00;
            gsl      <= 2'b00;
            wl0      <= 4'h0;
            wl1      <= 4'h0;
            sen1     <= 1'b0;
            sen2     <= 1'b0;
            out_en   <= 4'h0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            busy     <= busy_d;
            ssl      <= sel_d;
            gsl      <= sel_d;
            wl0      <= wl0_d;
            wl1      <= wl1_d;
            sen1     <= sen1_d;
            sen2     <= sen2_d;
            out_en   <= out_en_d;
            rd_valid <= rd_valid_d;
            rd_data  <= rd_data_d;
        end
    end

`ifdef FLASH_RD_DOUBLE_SENSE_EN
    logic [7:0] sample1_q;
    logic       err_q;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sample1_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            if (state_q == StLatch) begin
                sample1_q <= sa_out;
            end
            if (state_q == StLatch2) begin
                err_q <= (sa_out != sample1_q);
            end
        end
    end

    assign rd_err = err_q;
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_flash_read_seq.sv
// Directed self-checking bench for flash_read_seq (default and double-sense builds).
module tb_flash_read_seq;

`ifdef FLASH_RD_DOUBLE_SENSE_EN
    localparam bit DBL = 1'b1;
    localparam int LAT = 17;
    localparam int NSENSE = 2;
`else
    localparam bit DBL = 1'b0;
    localparam int LAT = 11;
    localparam int NSENSE = 1;
`endif

    logic       wb_clk_i = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_addr;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       busy;
    logic [1:0] ssl;
    logic [1:0] gsl;
    logic [3:0] wl0;
    logic [3:0] wl1;
    logic       sl;
    logic       vbpw;
    logic       sen1;
    logic       sen2;
    logic [3:0] out_en;
    logic [7:0] sa_out;

    int tests = 0;
    int fails = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    flash_read_seq dut (
        .wb_clk_i  (wb_clk_i),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .busy      (busy),
        .ssl       (ssl),
        .gsl       (gsl),
        .wl0       (wl0),
        .wl1       (wl1),
        .sl        (sl),
        .vbpw      (vbpw),
        .sen1      (sen1),
        .sen2      (sen2),
        .out_en    (out_en),
        .sa_out    (sa_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_lines_low(input string tag);
        check({tag, " lines"}, {ssl, gsl, wl0, wl1, sl, vbpw, sen1, sen2, out_en}, 32'h0);
    endtask

    // Issue one read at a negedge; sa_out switches to sa2 once the first latch is over.
    task automatic do_read(input logic [2:0] addr, input logic [7:0] sa1, input logic [7:0] sa2,
                           input logic [1:0] e_sel, input logic [3:0] e_wl0,
                           input logic [3:0] e_wl1);
        int n = 0;
        int n_sen1 = 0;
        int n_sen2 = 0;
        int n_oen = 0;
        int bad = 0;
        bit swapped = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        sa_out    = sa1;
        check("cmd_ready before accept", cmd_ready, 1'b1);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        check("ssl", ssl, e_sel);
        check("gsl", gsl, e_sel);
        check("wl0", wl0, e_wl0);
        check("wl1", wl1, e_wl1);
        check("busy", busy, 1'b1);
        check("cmd_ready busy", cmd_ready, 1'b0);
        while (!rd_valid && n < 40) begin
            if (n_oen == 1 && out_en == 4'h0 && !swapped) begin
                sa_out  = sa2;
                swapped = 1'b1;
            end
            if (sen1) n_sen1++;
            if (sen2) n_sen2++;
            if (out_en != 4'h0) begin
                n_oen++;
                if (out_en != 4'hF) bad++;
            end
            if ((sen1 && sen2) || (sen2 && out_en != 4'h0)) bad++;
            if (n < LAT - 1 && (ssl != e_sel || wl0 != e_wl0 || wl1 != e_wl1)) bad++;
            @(negedge wb_clk_i);
            n++;
        end
        check("latency", n, LAT);
        check("sen1 cycles", n_sen1, 2 * NSENSE);
        check("sen2 cycles", n_sen2, 3 * NSENSE);
        check("out_en cycles", n_oen, NSENSE);
        check("strobe overlap/hold", bad, 0);
        check("rd_data", rd_data, DBL ? sa2 : sa1);
        check("rd_err", rd_err, DBL && (sa1 != sa2));
        check_lines_low("after recov");
        check("cmd_ready with result", cmd_ready, 1'b0);
    endtask

    task automatic finish_read();
        check("rd_valid before handshake", rd_valid, 1'b1);
        rd_ready = 1'b1;
        @(negedge wb_clk_i);
        rd_ready = 1'b0;
        check("rd_valid cleared", rd_valid, 1'b0);
        check("cmd_ready after handshake", cmd_ready, 1'b1);
    endtask

    initial begin
        int bad;
        int n;
        logic [7:0] held;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 3'd0;
        rd_ready  = 1'b0;
        sa_out    = 8'h00;
        repeat (2) @(negedge wb_clk_i);
        check_lines_low("in reset");
        check("rd_data reset", rd_data, 8'h00);
        rst_n = 1'b1;

        bad = 0;
        repeat (20) begin
            @(negedge wb_clk_i);
            if (ssl | gsl | wl0 | wl1 | {3'b0, sen1} | {3'b0, sen2} | out_en) bad++;
            if (!cmd_ready || rd_valid || busy || rd_err) bad++;
        end
        check("idle 20 cycles", bad, 0);

        do_read(3'b010, 8'hA5, 8'hA5, 2'b01, 4'b1011, 4'h0);
        finish_read();

        // sa_out changes right after the latch: the result must be the latched value
        do_read(3'b111, 8'h5A, 8'hFF, 2'b10, 4'h0, 4'b0111);
        finish_read();

        do_read(3'b100, 8'h3C, 8'h3D, 2'b10, 4'h0, 4'b1110);
        held = rd_data;
        bad  = 0;
        repeat (10) begin
            cmd_valid = 1'b1;
            cmd_addr  = 3'b001;
            @(negedge wb_clk_i);
            if (rd_data != held || !rd_valid || cmd_ready || busy || ssl != 2'b00) bad++;
        end
        cmd_valid = 1'b0;
        check("backpressure hold", bad, 0);
        finish_read();

        do_read(3'b001, 8'h81, 8'h81, 2'b01, 4'b1101, 4'h0);
        finish_read();

        // Reset while sense strobe is up
        cmd_valid = 1'b1;
        cmd_addr  = 3'b011;
        sa_out    = 8'h77;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        n = 0;
        while (!sen2 && n < 20) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("reached sense", sen2, 1'b1);
        rst_n = 1'b0;
        #1;
        check_lines_low("async reset");
        check("busy in reset", busy, 1'b0);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge wb_clk_i);
            if (rd_valid || busy || sen1 || sen2 || out_en != 4'h0) bad++;
        end
        check("no result after reset", bad, 0);
        check("cmd_ready after reset", cmd_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
